// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the pipeline MEM stage (fixed priority)
// and a debug/loader port whose wait is bounded by a saturating denial counter.
module dmem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wren,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
  logic          dbg_rvalid_q, dbg_rvalid_d;
  logic          dbg_gnt, cpu_gnt;

  always_comb begin
    dbg_gnt = dbg_req & (~cpu_req | (wait_cnt_q == MaxWait));
    cpu_gnt = cpu_req & ~dbg_gnt;

    // Idle cycles still present the CPU address so a speculative read is harmless.
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_wren  = 1'b1;
    if (dbg_gnt) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_wren  = ~dbg_we;
    end else if (cpu_gnt) begin
      mem_wren  = ~cpu_we;
    end
    if (!rst_n) begin
      mem_wren = 1'b1;
    end

    wait_cnt_d = '0;
    if (dbg_req & ~dbg_gnt) begin
      wait_cnt_d = (wait_cnt_q == MaxWait) ? MaxWait : wait_cnt_q + 4'd1;
    end

    dbg_rvalid_d = dbg_gnt & ~dbg_we;
    dbg_rdata_d  = dbg_rvalid_d ? mem_rdata : dbg_rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q   <= '0;
      dbg_rdata_q  <= '0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      dbg_rdata_q  <= dbg_rdata_d;
      dbg_rvalid_q <= dbg_rvalid_d;
    end
  end

  assign cpu_rdata  = mem_rdata;
  assign cpu_stall  = cpu_req & ~cpu_gnt;
  assign dbg_ack    = dbg_gnt;
  assign dbg_rdata  = dbg_rdata_q;
  assign dbg_rvalid = dbg_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: attached 256x8 memory, directed scenarios, then random traffic
// compared against a model that counts DBG denials and keeps its own memory image.
module tb_dmem_arbiter;

  localparam int MAX_WAIT = 4;

  logic       clk;
  logic       rst_n;
  logic       cpu_req, cpu_we;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       cpu_stall;
  logic       dbg_req, dbg_we;
  logic [7:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic       dbg_ack, dbg_rvalid;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_wren;

  logic [7:0] mem_arr [256];

  int         n_checks = 0;
  int         n_errors = 0;

  // model state
  logic [7:0] ref_mem [256];
  int         ref_denied;
  logic       exp_rvalid;
  logic [7:0] exp_rdata;
  logic       last_ack;

  dmem_arbiter #(.AW(8), .DW(8), .MAX_WAIT(MAX_WAIT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_ack    (dbg_ack),
    .dbg_rdata  (dbg_rdata),
    .dbg_rvalid (dbg_rvalid),
    .mem_addr   (mem_addr),
    .mem_wren   (mem_wren),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!mem_wren) mem_arr[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem_arr[mem_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output with the model for the current inputs, then advance the model
  // to what the coming rising edge should produce.
  task automatic eval_cycle();
    logic       e_dgnt, e_cgnt, e_wren;
    logic [7:0] e_addr, e_wdata;
    e_dgnt  = dbg_req && (!cpu_req || ref_denied >= MAX_WAIT);
    e_cgnt  = cpu_req && !e_dgnt;
    e_wren  = e_dgnt ? !dbg_we : (e_cgnt ? !cpu_we : 1'b1);
    e_addr  = e_dgnt ? dbg_addr : cpu_addr;
    e_wdata = e_dgnt ? dbg_wdata : cpu_wdata;
    check_eq("dbg_ack",    32'(dbg_ack),    32'(e_dgnt));
    check_eq("cpu_stall",  32'(cpu_stall),  32'(cpu_req && !e_cgnt));
    check_eq("mem_wren",   32'(mem_wren),   32'(e_wren));
    check_eq("mem_addr",   32'(mem_addr),   32'(e_addr));
    check_eq("mem_wdata",  32'(mem_wdata),  32'(e_wdata));
    check_eq("cpu_rdata",  32'(cpu_rdata),  32'(ref_mem[e_addr]));
    check_eq("dbg_rvalid", 32'(dbg_rvalid), 32'(exp_rvalid));
    check_eq("dbg_rdata",  32'(dbg_rdata),  32'(exp_rdata));

    if (e_dgnt && !dbg_we) begin
      exp_rvalid = 1'b1;
      exp_rdata  = ref_mem[dbg_addr];
    end else begin
      exp_rvalid = 1'b0;
    end
    if (e_dgnt && dbg_we)      ref_mem[dbg_addr] = dbg_wdata;
    else if (e_cgnt && cpu_we) ref_mem[cpu_addr] = cpu_wdata;
    ref_denied = (dbg_req && !e_dgnt) ? ref_denied + 1 : 0;
    last_ack   = e_dgnt;
  endtask

  task automatic cyc(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                     input logic dr, input logic dw, input logic [7:0] da, input logic [7:0] dd);
    @(posedge clk);
    #1;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
    #3;
    eval_cycle();
  endtask

  // Asynchronous reset pulse between edges with the current inputs held.
  task automatic pulse_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    ref_denied = 0;
    exp_rvalid = 1'b0;
    exp_rdata  = 8'h00;
    #1;
    check_eq("rst_mem_wren",   32'(mem_wren),   32'(1));
    check_eq("rst_dbg_rvalid", 32'(dbg_rvalid), 32'(0));
    check_eq("rst_dbg_rdata",  32'(dbg_rdata),  32'(0));
    #1;
    rst_n = 1'b1;
    #1;
    eval_cycle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_cycle, stall_cnt, wait_steps;
    logic       r_cr, r_cw, r_dr, r_dw;
    logic [7:0] r_ca, r_cd, r_da, r_dd;

    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    ref_denied = 0;
    exp_rvalid = 1'b0;
    exp_rdata  = 8'h00;
    last_ack   = 1'b0;
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 8'h00; dbg_wdata = 8'h00;
    #8;
    check_eq("reset_rvalid",   32'(dbg_rvalid), 32'(0));
    check_eq("reset_rdata",    32'(dbg_rdata),  32'(0));
    check_eq("reset_mem_wren", 32'(mem_wren),   32'(1));
    cpu_req = 1'b1; cpu_we = 1'b1;
    #1;
    check_eq("reset_wren_forced", 32'(mem_wren), 32'(1));
    cpu_req = 1'b0; cpu_we = 1'b0;
    #3;
    rst_n = 1'b1;

    // 1: CPU write then zero-latency read back
    cyc(1, 1, 8'h90, 8'hDB, 0, 0, 8'h00, 8'h00);
    check_eq("t1_wren", 32'(mem_wren), 32'(0));
    check_eq("t1_addr", 32'(mem_addr), 32'(8'h90));
    cyc(1, 0, 8'h90, 8'h00, 0, 0, 8'h00, 8'h00);
    check_eq("t1_rdata", 32'(cpu_rdata), 32'(8'hDB));

    // 2: DBG read with CPU idle, one-cycle latency
    cyc(0, 0, 8'h00, 8'h00, 1, 0, 8'h90, 8'h00);
    check_eq("t2_ack", 32'(dbg_ack), 32'(1));
    cyc(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    check_eq("t2_rvalid", 32'(dbg_rvalid), 32'(1));
    check_eq("t2_rdata",  32'(dbg_rdata),  32'(8'hDB));
    cyc(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    check_eq("t2_rvalid_drop", 32'(dbg_rvalid), 32'(0));

    // 3: starvation bound under continuous CPU traffic
    ack_cycle = -1;
    stall_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1, 0, 8'h20, 8'h00, (k >= 2) && (ack_cycle < 0), 1, 8'h85, 8'h15);
      if (dbg_ack) ack_cycle = k;
      if (cpu_stall) stall_cnt++;
    end
    check_eq("t3_ack_cycle", 32'(ack_cycle), 32'(2 + MAX_WAIT));
    check_eq("t3_stall_cnt", 32'(stall_cnt), 32'(1));

    // 4: same-address write conflict, CPU wins first
    cyc(1, 1, 8'h82, 8'h02, 1, 1, 8'h82, 8'h77);
    check_eq("t4_cpu_wins", 32'(dbg_ack), 32'(0));
    cyc(0, 0, 8'h82, 8'h00, 1, 1, 8'h82, 8'h77);
    check_eq("t4_dbg_ack",  32'(dbg_ack),   32'(1));
    check_eq("t4_cpu_data", 32'(cpu_rdata), 32'(8'h02));
    cyc(1, 0, 8'h82, 8'h00, 0, 0, 8'h00, 8'h00);
    check_eq("t4_dbg_data", 32'(cpu_rdata), 32'(8'h77));

    // 5: reset mid-wait restarts the full wait
    for (int k = 0; k < 3; k++) cyc(1, 1, 8'h40, 8'h5A, 1, 0, 8'h85, 8'h00);
    pulse_reset();
    wait_steps = -1;
    for (int k = 1; k <= 10 && wait_steps < 0; k++) begin
      cyc(1, 1, 8'h40, 8'h5A, 1, 0, 8'h85, 8'h00);
      if (dbg_ack) wait_steps = k;
    end
    check_eq("t5_wait_after_reset", 32'(wait_steps), 32'(MAX_WAIT));
    cyc(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    check_eq("t5_rdata", 32'(dbg_rdata), 32'(8'h15));

    // 6: back-to-back DBG reads with CPU idle
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 8'h00, 8'h00, 1, 0, 8'(8'h82 + i), 8'h00);
      check_eq("t6_ack", 32'(dbg_ack), 32'(1));
      if (i > 0) check_eq("t6_rvalid", 32'(dbg_rvalid), 32'(1));
      if (i == 1) check_eq("t6_first", 32'(dbg_rdata), 32'(8'h77));
      if (i == 4) check_eq("t6_fourth", 32'(dbg_rdata), 32'(8'h15));
    end
    cyc(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    check_eq("t6_last_rvalid", 32'(dbg_rvalid), 32'(1));
    cyc(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    check_eq("t6_idle_rvalid", 32'(dbg_rvalid), 32'(0));

    // random traffic over a small address window to force collisions
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(199) == 0) begin
        pulse_reset();
      end else begin
        r_cr = ($urandom_range(99) < 65);
        r_cw = 1'($urandom_range(1));
        r_ca = 8'($urandom_range(15));
        r_cd = 8'($urandom);
        if (!dbg_req || last_ack) begin
          r_dr = ($urandom_range(99) < 45);
          r_dw = 1'($urandom_range(1));
          r_da = 8'($urandom_range(15));
          r_dd = 8'($urandom);
        end else begin
          r_dr = dbg_req; r_dw = dbg_we; r_da = dbg_addr; r_dd = dbg_wdata;
        end
        cyc(r_cr, r_cw, r_ca, r_cd, r_dr, r_dw, r_da, r_dd);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 8-bit data memory between two requesters: the pipeline MEM stage (CPU port) and a debug/loader port (DBG port).
- The CPU has fixed priority. A wait counter guarantees the DBG port is granted within a bounded number of cycles.
- Drives the memory's address, active-low write enable and write data. Stalls the CPU when it loses arbitration.
- Returns read data combinationally to the CPU and as a registered response to DBG.

Parameters:
- AW, 8, address width (256-entry memory).
- DW, 8, data width.
- MAX_WAIT, 4, maximum consecutive cycles a pending DBG request is denied (legal range 1..15).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request this cycle.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_rdata  out  DW  CPU read data, combinational from mem_rdata.
- cpu_stall  out  1  CPU request not served this cycle; pipeline must hold.
- dbg_req  in  1  DBG request; held with payload until dbg_ack.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_addr  in  AW  DBG address.
- dbg_wdata  in  DW  DBG write data.
- dbg_ack  out  1  DBG request granted this cycle (combinational).
- dbg_rdata  out  DW  registered DBG read data.
- dbg_rvalid  out  1  one-cycle pulse; dbg_rdata valid.
- mem_addr  out  AW  to memory address.
- mem_wren  out  1  to memory write enable, ACTIVE-LOW (0 = write at next rising edge).
- mem_wdata  out  DW  to memory write data.
- mem_rdata  in  DW  from memory combinational read data.

Behaviour:
- State: wait_cnt (4 bits), dbg_rdata, dbg_rvalid. No other registers; grant logic is combinational from the inputs and wait_cnt.
- Grant rule:
  - dbg_gnt = dbg_req & (~cpu_req | wait_cnt == MAX_WAIT).
  - cpu_gnt = cpu_req & ~dbg_gnt.
- Status outputs:
  - dbg_ack = dbg_gnt.
  - cpu_stall = cpu_req & ~cpu_gnt.
- Memory mux:
  - dbg_gnt: mem_addr = dbg_addr, mem_wdata = dbg_wdata, mem_wren = ~dbg_we.
  - cpu_gnt: mem_addr = cpu_addr, mem_wdata = cpu_wdata, mem_wren = ~cpu_we.
  - Neither granted: mem_addr = cpu_addr, mem_wdata = cpu_wdata, mem_wren = 1 (no write).
- Memory write commits on the rising edge that ends the grant cycle.
- CPU read: cpu_rdata = mem_rdata, same cycle, zero latency. The value is meaningful only when cpu_gnt & ~cpu_we.
- DBG read: on the edge ending a dbg_gnt & ~dbg_we cycle, dbg_rdata <= mem_rdata and dbg_rvalid <= 1. Otherwise dbg_rvalid <= 0 and dbg_rdata holds. Read latency is 1 cycle after dbg_ack.
- DBG write: dbg_ack only, no rvalid.
- wait_cnt update:
  - dbg_req & ~dbg_gnt: wait_cnt <= wait_cnt + 1, saturating at MAX_WAIT.
  - dbg_gnt or ~dbg_req: wait_cnt <= 0.
- Starvation bound: under continuous cpu_req, a DBG request raised at cycle t is acked at cycle t + MAX_WAIT. cpu_stall is high in exactly that cycle.
- DBG handshake: dbg_req held high in the cycle after dbg_ack is a new request. It re-arbitrates from wait_cnt = 0, so the CPU wins back the next cycle if requesting.
- Simultaneous CPU and DBG writes to the same address: only the granted port's data is written; the loser retries in a later cycle.
- Read-after-write to the same address in consecutive grant cycles returns the new data, since the write committed at the edge between them.
- Reset (asynchronous, any time, including mid-wait or in a grant cycle):
  - wait_cnt = 0, dbg_rdata = 0, dbg_rvalid = 0.
  - Combinational outputs follow the inputs immediately.
  - mem_wren is forced to 1 while rst_n = 0, so no memory write occurs during reset.

Test Plan:
1. Idle → CPU write: cpu_req=1, we=1, addr=0x90, wdata=0xDB (987 & 0xFF) → mem_wren=0, mem_addr=0x90, cpu_stall=0. Next cycle CPU read 0x90 → cpu_rdata=0xDB, same cycle.
2. DBG only: dbg_req=1, we=0, addr=0x90 with cpu_req=0 → dbg_ack=1 that cycle; next cycle dbg_rvalid=1, dbg_rdata=0xDB; following cycle dbg_rvalid=0.
3. Starvation bound: cpu_req held 1 for 10 cycles, dbg_req raised at cycle 2 (write 0x85 ← 0x15) → dbg_ack only at cycle 6. cpu_stall=1 only at cycle 6. wait_cnt values in cycles 2..6: 0,1,2,3,4, then 0.
4. Same-cycle conflict: CPU write 0x82←0x02 and DBG write 0x82←0x77 with wait_cnt=0 → CPU wins, memory 0x82=0x02. DBG is acked later and memory becomes 0x77.
5. Reset mid-wait: wait_cnt=3 with dbg_req pending, pulse rst_n low asynchronously between edges → wait_cnt=0, dbg_rvalid=0, mem_wren=1 during reset. After release, DBG waits the full MAX_WAIT again.
6. Back-to-back DBG with CPU idle: dbg_req held high for reads of 0x82..0x8B changing addr after each ack → one ack per cycle, 10 consecutive dbg_rvalid pulses returning the stored values in order.
